// File: rtl/msd_pkg.sv
// Shared types and width helpers for the multi-pattern sequence detector.
package msd_pkg;

   // Controller states: IDLE until the first newstream, PRIME until the
   // first word after a newstream, then RUN.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Width of the priority index output. It is never narrower than one bit.
   function automatic int index_width(input int num);
      return (clog2(num) < 1) ? 1 : clog2(num);
   endfunction

endpackage

// File: rtl/msd_window_match.sv
// Compares one masked pattern against every bit offset of the history
// window {tail, word}. The module is purely combinational.
module msd_window_match #(
   parameter int WID_Bitstream = 16,
   parameter int WID_Compair   = 8
) (
   input  logic [WID_Bitstream+WID_Compair-2:0] history,
   input  logic [WID_Compair-1:0]               pattern,
   input  logic [WID_Compair-1:0]               mask,
   input  logic                                 enable,
   input  logic                                 prime,
   output logic [WID_Bitstream-1:0]             position
);

   // Match every offset. While priming, the high offsets would read a
   // cleared tail, so they are forced to zero.
   always_comb begin
      position = '0;
      for (int i = 0; i < WID_Bitstream; i++) begin
         if (enable && (((history[i +: WID_Compair] ^ pattern) & mask) == '0))
            position[i] = 1'b1;
         if (prime && (i > WID_Bitstream - WID_Compair))
            position[i] = 1'b0;
      end
   end

endmodule

// File: rtl/multi_sequence_detector.sv
// Streaming multi-pattern bit-sequence detector. Each accepted word is
// matched at every bit offset against NUM_Pattern masked patterns. The
// history tail carries matches across word boundaries. Results leave
// through a one-deep registered valid/ready stage.
//
// Handshake: an input word transfers on a rising edge where
// local_MSD_valid && MSD_local_ready. A result transfers where
// MSD_local_valid && local_MSD_ready. A pending result is held stable
// until it transfers. An accept and a transfer in the same cycle replace
// the result without a bubble.
module multi_sequence_detector
   import msd_pkg::*;
#(
   parameter int WID_Bitstream = 16,
   parameter int WID_Compair   = 8,
   parameter int NUM_Pattern   = 4,
   parameter int WID_Count     = 16
) (
   input  logic                                 local_MSD_clk,
   input  logic                                 local_MSD_reset,
   input  logic                                 local_MSD_newstream,
   input  logic [NUM_Pattern*WID_Compair-1:0]   local_MSD_pattern,
   input  logic [NUM_Pattern*WID_Compair-1:0]   local_MSD_mask,
   input  logic [NUM_Pattern-1:0]               local_MSD_enable,
   input  logic                                 local_MSD_valid,
   output logic                                 MSD_local_ready,
   input  logic [WID_Bitstream-1:0]             local_MSD_bitstream,
   output logic                                 MSD_local_valid,
   input  logic                                 local_MSD_ready,
   output logic [NUM_Pattern*WID_Bitstream-1:0] MSD_local_position,
   output logic [NUM_Pattern-1:0]               MSD_local_hit,
   output logic [index_width(NUM_Pattern)-1:0]  MSD_local_first,
   output logic [WID_Count-1:0]                 MSD_local_total,
   output logic                                 MSD_local_busy,
   output logic [1:0]                           MSD_local_state
);

   localparam int WID_Index = index_width(NUM_Pattern);
   localparam int WID_Tail  = WID_Compair - 1;

   state_t                             state_q, state_d;
   logic [NUM_Pattern*WID_Compair-1:0] pattern_q, pattern_d;
   logic [NUM_Pattern*WID_Compair-1:0] mask_q, mask_d;
   logic [NUM_Pattern-1:0]             enable_q, enable_d;
   logic [WID_Tail-1:0]                tail_q, tail_d;
   logic                               valid_q, valid_d;
   logic [NUM_Pattern*WID_Bitstream-1:0] position_q, position_d;
   logic [NUM_Pattern-1:0]             hit_q, hit_d;
   logic [WID_Index-1:0]               first_q, first_d;
   logic [WID_Count-1:0]               total_q, total_d;

   logic [WID_Bitstream+WID_Tail-1:0]    history;
   logic                                 prime_c;
   logic                                 ready_c;
   logic                                 accept_c;
   logic [NUM_Pattern*WID_Bitstream-1:0] match_pos;
   logic [NUM_Pattern-1:0]               match_hit;
   logic [WID_Index-1:0]                 match_first;

   assign history  = {tail_q, local_MSD_bitstream};
   assign prime_c  = (state_q == PRIME);
   assign ready_c  = (state_q != IDLE) && !local_MSD_newstream &&
                     (!valid_q || local_MSD_ready);
   assign accept_c = local_MSD_valid && ready_c;

   for (genvar p = 0; p < NUM_Pattern; p++) begin : g_match
      msd_window_match #(
         .WID_Bitstream (WID_Bitstream),
         .WID_Compair   (WID_Compair)
      ) u_match (
         .history  (history),
         .pattern  (pattern_q[p*WID_Compair +: WID_Compair]),
         .mask     (mask_q[p*WID_Compair +: WID_Compair]),
         .enable   (enable_q[p]),
         .prime    (prime_c),
         .position (match_pos[p*WID_Bitstream +: WID_Bitstream])
      );
   end

   // Per-pattern hit summary and a lowest-index-wins priority encoder.
   always_comb begin
      match_hit   = '0;
      match_first = '0;
      for (int p = 0; p < NUM_Pattern; p++)
         match_hit[p] = |match_pos[p*WID_Bitstream +: WID_Bitstream];
      for (int p = NUM_Pattern - 1; p >= 0; p--)
         if (match_hit[p]) match_first = WID_Index'(p);
   end

   // Next-state logic. newstream overrides everything, then accept, then drain.
   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      mask_d     = mask_q;
      enable_d   = enable_q;
      tail_d     = tail_q;
      valid_d    = valid_q;
      position_d = position_q;
      hit_d      = hit_q;
      first_d    = first_q;
      total_d    = total_q;
      if (local_MSD_newstream) begin
         state_d    = PRIME;
         pattern_d  = local_MSD_pattern;
         mask_d     = local_MSD_mask;
         enable_d   = local_MSD_enable;
         tail_d     = '0;
         valid_d    = 1'b0;
         position_d = '0;
         hit_d      = '0;
         first_d    = '0;
         total_d    = '0;
      end else if (accept_c) begin
         state_d    = RUN;
         tail_d     = local_MSD_bitstream[WID_Tail-1:0];
         valid_d    = 1'b1;
         position_d = match_pos;
         hit_d      = match_hit;
         first_d    = match_first;
         if ((|match_hit) && (total_q != {WID_Count{1'b1}}))
            total_d = total_q + WID_Count'(1);
      end else if (valid_q && local_MSD_ready) begin
         valid_d = 1'b0;
      end
   end

   // Controller state, configuration, history tail and result registers.
   always_ff @(posedge local_MSD_clk or negedge local_MSD_reset) begin
      if (!local_MSD_reset) begin
         state_q    <= IDLE;
         pattern_q  <= '0;
         mask_q     <= '0;
         enable_q   <= '0;
         tail_q     <= '0;
         valid_q    <= 1'b0;
         position_q <= '0;
         hit_q      <= '0;
         first_q    <= '0;
         total_q    <= '0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         mask_q     <= mask_d;
         enable_q   <= enable_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         position_q <= position_d;
         hit_q      <= hit_d;
         first_q    <= first_d;
         total_q    <= total_d;
      end
   end

   assign MSD_local_ready    = ready_c;
   assign MSD_local_valid    = valid_q;
   assign MSD_local_position = position_q;
   assign MSD_local_hit      = hit_q;
   assign MSD_local_first    = first_q;
   assign MSD_local_total    = total_q;
   assign MSD_local_busy     = (state_q != IDLE) || valid_q;
   assign MSD_local_state    = state_q;

endmodule

// File: tb/tb_multi_sequence_detector.sv
// Bench for multi_sequence_detector with W=8, C=4, N=2 and a 2-bit counter.
// The reference keeps the received bit history as a queue in arrival order.
// A pattern matches when the C most recent bits ending at a given word bit
// equal it under the mask.
module tb_multi_sequence_detector;
  import msd_pkg::*;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int N  = 2;
  localparam int CW = 2;
  localparam int IW = 1;
  localparam int RW = N*W + N + IW + CW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ns = 1'b0;
  logic [N*C-1:0] pat = '0;
  logic [N*C-1:0] msk = '0;
  logic [N-1:0]   en = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   word = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] pos;
  logic [N-1:0]   hit;
  logic [IW-1:0]  first;
  logic [CW-1:0]  total;
  logic           busy;
  logic [1:0]     dbg_state;

  multi_sequence_detector #(
    .WID_Bitstream (W),
    .WID_Compair   (C),
    .NUM_Pattern   (N),
    .WID_Count     (CW)
  ) dut (
    .local_MSD_clk       (clk),
    .local_MSD_reset     (rst_n),
    .local_MSD_newstream (ns),
    .local_MSD_pattern   (pat),
    .local_MSD_mask      (msk),
    .local_MSD_enable    (en),
    .local_MSD_valid     (in_valid),
    .MSD_local_ready     (in_ready),
    .local_MSD_bitstream (word),
    .MSD_local_valid     (out_valid),
    .local_MSD_ready     (out_ready),
    .MSD_local_position  (pos),
    .MSD_local_hit       (hit),
    .MSD_local_first     (first),
    .MSD_local_total     (total),
    .MSD_local_busy      (busy),
    .MSD_local_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int dut_acc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  bit             m_active = 1'b0;
  bit             m_bits[$];
  logic [N*C-1:0] m_pat = '0;
  logic [N*C-1:0] m_msk = '0;
  logic [N-1:0]   m_en = '0;
  int             m_total = 0;
  logic [RW-1:0]  exp_q[$];

  task automatic model_accept(input logic [W-1:0] w);
    logic [N*W-1:0] p_pos;
    logic [N-1:0]   p_hit;
    logic [IW-1:0]  p_first;
    bit             found;
    for (int b = W - 1; b >= 0; b--) m_bits.push_back(w[b]);
    p_pos = '0;
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < W; i++) begin
        int last;
        int start;
        bit ok;
        last  = m_bits.size() - 1 - i;
        start = last - (C - 1);
        if (m_en[p] && start >= 0) begin
          ok = 1'b1;
          for (int k = 0; k < C; k++)
            if (m_msk[p*C + C-1-k] && (m_bits[start+k] != m_pat[p*C + C-1-k])) ok = 1'b0;
          p_pos[p*W + i] = ok;
        end
      end
    end
    for (int p = 0; p < N; p++) p_hit[p] = |p_pos[p*W +: W];
    p_first = '0;
    found = 1'b0;
    for (int p = 0; p < N; p++)
      if (p_hit[p] && !found) begin
        p_first = IW'(p);
        found = 1'b1;
      end
    if ((|p_hit) && m_total < (1 << CW) - 1) m_total++;
    while (m_bits.size() > C - 1) void'(m_bits.pop_front());
    exp_q.push_back({p_pos, p_hit, p_first, CW'(m_total)});
  endtask

  // driver: one clock of stimulus; checks at the falling edge, then the model advances
  task automatic step(input bit s_ns, input bit s_v, input logic [W-1:0] s_w, input bit s_rdy);
    bit exp_ready;
    ns = s_ns;
    in_valid = s_v;
    word = s_w;
    out_ready = s_rdy;
    @(negedge clk);
    exp_ready = m_active && !s_ns && (exp_q.size() == 0 || s_rdy);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("busy", busy, m_active || exp_q.size() != 0);
    check("total", total, m_total);
    if (exp_q.size() != 0) check("result", {pos, hit, first, total}, exp_q[0]);
    if (in_valid && in_ready) dut_acc++;
    if (s_ns) begin
      m_active = 1'b1;
      m_bits.delete();
      exp_q.delete();
      m_total = 0;
      m_pat = pat;
      m_msk = msk;
      m_en = en;
    end else begin
      if (exp_q.size() != 0 && s_rdy) void'(exp_q.pop_front());
      if (s_v && exp_ready) model_accept(s_w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_outs", {pos, hit, first, total, busy, in_ready}, '0);
    check("rst_state", dbg_state, IDLE);
    m_active = 1'b0;
    exp_q.delete();
    m_bits.delete();
    m_total = 0;
    ns = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [N*W-1:0] held;
  int             acc_base;
  bit             r_ns;

  initial begin
    // reset held low with traffic present
    in_valid = 1'b1;
    word = 8'hFF;
    out_ready = 1'b1;
    #12;
    check("t1_outs", {pos, hit, first, total, out_valid}, '0);
    check("t1_ready", in_ready, 1'b0);
    check("t1_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hB0, 1'b1);
    check("t1_idle_pos", pos, '0);
    check("t1_idle_state", dbg_state, IDLE);

    // single match on the first word
    pat = 8'h0B; msk = 8'h0F; en = 2'b01;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hB0, 1'b1);
    check("t2_pos", pos, 16'h0010);
    check("t2_hit", hit, 2'b01);
    check("t2_first", first, 1'b0);
    check("t2_total", total, 2'd1);

    // match straddling a word boundary
    step(1'b0, 1'b1, 8'h05, 1'b1);
    check("t3_nohit", hit, 2'b00);
    step(1'b0, 1'b1, 8'hC0, 1'b1);
    check("t3_pos", pos, 16'h0080);
    check("t3_total", total, 2'd2);

    // masked match on pattern 1
    pat = 8'h80; msk = 8'h90; en = 2'b10;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hE0, 1'b1);
    check("t4_pos", pos, 16'h1C00);
    check("t4_hit", hit, 2'b10);
    check("t4_first", first, 1'b1);

    // backpressure and counter saturation
    pat = 8'h00; msk = 8'h00; en = 2'b01;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    acc_base = dut_acc;
    step(1'b0, 1'b1, 8'h11, 1'b1);
    held = pos;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h22, 1'b0);
      check("t5_hold", pos, held);
      check("t5_ready", in_ready, 1'b0);
    end
    step(1'b0, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t5_accepts", dut_acc - acc_base, 5);
    check("t5_total", total, 2'd3);

    // newstream together with a valid word
    step(1'b0, 1'b1, 8'h66, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    check("t6_valid", out_valid, 1'b0);
    check("t6_total", total, 2'd0);
    check("t6_pos", pos, '0);
    check("t6_busy", busy, 1'b1);

    // reset while a result is pending
    step(1'b0, 1'b1, 8'h88, 1'b0);
    check("t6_pending", out_valid, 1'b1);
    do_reset();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0 && $urandom_range(0, 599) == 0) do_reset();
      r_ns = !m_active || ($urandom_range(0, 39) == 0);
      if (r_ns) begin
        pat = (N*C)'($urandom);
        msk = (N*C)'($urandom);
        en  = N'($urandom);
      end
      step(r_ns, $urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
